// File: rtl/fc_weight_loader.sv
// fc_weight_loader
// Packs a byte-serial stream of signed weights into 16-lane rows and writes
// each row to the FC weight memory with a one-cycle active-low strobe.
// Optional feature: define FC_LOADER_CHECKSUM_EN to append a modular checksum
// byte after the last row and report a mismatch on load_error.

module fc_weight_loader #(
  parameter int DATA_WIDTH       = 8,
  parameter int FLATTENED_LENGTH = 432
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         in_valid,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  output logic                         in_ready,
  output logic                         fullyconnected_WrEn,
  output logic [4:0]                   address_w,
  output logic signed [DATA_WIDTH-1:0] fullyconnected_weights_input [16],
  output logic                         busy,
  output logic                         done,
  output logic                         load_error
);

  localparam int         NUM_ROWS = FLATTENED_LENGTH / 16;
  localparam logic [4:0] LAST_ROW = 5'(NUM_ROWS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    WRITE = 3'd2,
`ifdef FC_LOADER_CHECKSUM_EN
    CHECK = 3'd3,
`endif
    DONE  = 3'd4
  } state_t;

  state_t     state;
  state_t     next_state;
  logic [3:0] lane_cnt;
  logic [4:0] row_cnt;
  logic       take_byte;
`ifdef FC_LOADER_CHECKSUM_EN
  logic       take_check;
`endif

  // State register; reset drops straight back to IDLE mid-load
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode; abort always wins over a transfer in the same cycle
  always_comb begin
    next_state = state;
    take_byte  = 1'b0;
`ifdef FC_LOADER_CHECKSUM_EN
    take_check = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start) next_state = FILL;
      end
      FILL: begin
        if (abort) begin
          next_state = IDLE;
        end else if (in_valid && in_ready) begin
          take_byte = 1'b1;
          if (lane_cnt == 4'd15) next_state = WRITE;
        end
      end
      WRITE: begin
        if (abort) begin
          next_state = IDLE;
        end else if (row_cnt == LAST_ROW) begin
`ifdef FC_LOADER_CHECKSUM_EN
          next_state = CHECK;
`else
          next_state = DONE;
`endif
        end else begin
          next_state = FILL;
        end
      end
`ifdef FC_LOADER_CHECKSUM_EN
      CHECK: begin
        if (abort) begin
          next_state = IDLE;
        end else if (in_valid && in_ready) begin
          take_check = 1'b1;
          next_state = DONE;
        end
      end
`endif
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Registered outputs decoded from the next state, plus lane/row datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ready            <= 1'b0;
      fullyconnected_WrEn <= 1'b1;
      address_w           <= 5'd0;
      busy                <= 1'b0;
      done                <= 1'b0;
      lane_cnt            <= 4'd0;
      row_cnt             <= 5'd0;
      for (int k = 0; k < 16; k++) begin
        fullyconnected_weights_input[k] <= '0;
      end
    end else begin
`ifdef FC_LOADER_CHECKSUM_EN
      in_ready <= (next_state == FILL) || (next_state == CHECK);
`else
      in_ready <= (next_state == FILL);
`endif
      fullyconnected_WrEn <= (next_state != WRITE);
      busy                <= (next_state != IDLE);
      done                <= (next_state == DONE);
      if (next_state == WRITE) begin
        address_w <= row_cnt;
      end
      if (state == IDLE && start) begin
        lane_cnt <= 4'd0;
        row_cnt  <= 5'd0;
      end
      if (take_byte) begin
        fullyconnected_weights_input[lane_cnt] <= in_data;
        lane_cnt                               <= lane_cnt + 4'd1;
      end
      if (state == WRITE && next_state == FILL) begin
        row_cnt <= row_cnt + 5'd1;
      end
    end
  end

`ifdef FC_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum;

  // Wrapping sum of accepted weights, compared against the trailing checksum byte
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum        <= '0;
      load_error <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        sum        <= '0;
        load_error <= 1'b0;
      end else if (take_byte) begin
        sum <= sum + in_data;
      end
      if (take_check) begin
        load_error <= (sum != in_data);
      end
    end
  end
`else
  assign load_error = 1'b0;
`endif

endmodule
